reject_sample_collector: RTL and testbench

- Receive-side consumer of the reject sampler core's output stream (sample_tdata, acc_bus, sample_tvalid).
- Compacts the accepted lanes of each beat in lane order and writes them into an internal N_COEFF-entry coefficient buffer.
- Asserts done when the polynomial is full and exposes a registered read port for the downstream NTT/packing logic.
- The sampler has no backpressure, so this block accepts a beat every cycle while collecting.

---
 rtl/reject_sample_collector.sv | 142 ++++++++++++++
 tb/tb_reject_sample_collector.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reject_sample_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reject_sample_collector: packs accepted sampler lanes into a coefficient   |
// | buffer and raises done once the polynomial is full.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module reject_sample_collector #(
  parameter int LANES     = 4,
  parameter int CAND_BITS = 12,
  parameter int N_COEFF   = 256,
  parameter int Q         = 3329
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          sample_tvalid,
  input  logic [LANES*CAND_BITS-1:0]    sample_tdata,
  input  logic [LANES-1:0]              acc_bus,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(N_COEFF):0]      count,
  output logic                          range_err,
  input  logic [$clog2(N_COEFF)-1:0]    rd_addr,
  output logic [CAND_BITS-1:0]          rd_data
);

  localparam int AW = $clog2(N_COEFF);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  localparam logic [CW-1:0]        C_FULL = CW'(N_COEFF);
  localparam logic [CW-1:0]        C_ONE  = CW'(1);
  localparam logic [CAND_BITS:0]   C_Q    = (CAND_BITS+1)'(Q);

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 range_err_q, range_err_d;
  logic [CAND_BITS-1:0] rd_data_q, rd_data_d;

  logic [CAND_BITS-1:0] buf_q [N_COEFF];

  logic [CAND_BITS-1:0] lane_data [LANES];
  logic [AW-1:0]        wr_addr   [LANES];
  logic [LANES-1:0]     wr_en;
  logic [CW-1:0]        n_wr;
  logic                 lane_oor;
  logic                 beat_ok;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_data[i] = sample_tdata[i*CAND_BITS +: CAND_BITS];
  end

  // Each accepted lane lands at count + (accepted lanes below it); lanes whose
  // slot falls past the end of the buffer are dropped and not range-checked.
  always_comb begin : p_compact
    logic [CW-1:0] rank;
    logic [CW-1:0] slot;
    beat_ok  = (state_q == S_COLLECT) && sample_tvalid && !start && !rst;
    rank     = '0;
    slot     = '0;
    n_wr     = '0;
    lane_oor = 1'b0;
    wr_en    = '0;
    for (int i = 0; i < LANES; i++) begin
      slot       = count_q + rank;
      wr_addr[i] = slot[AW-1:0];
      wr_en[i]   = beat_ok && acc_bus[i] && (slot < C_FULL);
      if (acc_bus[i]) begin
        rank = rank + C_ONE;
      end
      if (wr_en[i]) begin
        n_wr = n_wr + C_ONE;
        if ({1'b0, lane_data[i]} >= C_Q) begin
          lane_oor = 1'b1;
        end
      end
    end
  end

  always_comb begin : p_next
    state_d     = state_q;
    count_d     = count_q;
    range_err_d = range_err_q;
    rd_data_d   = buf_q[rd_addr];
    if (start) begin
      state_d     = S_COLLECT;
      count_d     = '0;
      range_err_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE:    state_d = S_IDLE;
        S_COLLECT: begin
          count_d = count_q + n_wr;
          if (lane_oor) begin
            range_err_d = 1'b1;
          end
          if (count_d == C_FULL) begin
            state_d = S_DONE;
          end
        end
        S_DONE:    state_d = S_DONE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin : p_out
    busy      = (state_q == S_COLLECT);
    done      = (state_q == S_DONE);
    count     = count_q;
    range_err = range_err_q;
    rd_data   = rd_data_q;
  end

  always_ff @(posedge clk) begin : p_regs
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      range_err_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      range_err_q <= range_err_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Buffer is never cleared; a same-edge read of a written slot sees old data.
  always_ff @(posedge clk) begin : p_buf
    for (int i = 0; i < LANES; i++) begin
      if (wr_en[i]) begin
        buf_q[wr_addr[i]] <= lane_data[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reject_sample_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_reject_sample_collector: scoreboard bench for reject_sample_collector.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_reject_sample_collector;

  localparam int N = 256;
  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sample_tvalid;
  logic [47:0] sample_tdata;
  logic [3:0]  acc_bus;
  logic        busy;
  logic        done;
  logic [8:0]  count;
  logic        range_err;
  logic [7:0]  rd_addr;
  logic [11:0] rd_data;

  reject_sample_collector #(
    .LANES(4), .CAND_BITS(12), .N_COEFF(N), .Q(Q)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sample_tvalid(sample_tvalid),
    .sample_tdata(sample_tdata), .acc_bus(acc_bus), .busy(busy), .done(done),
    .count(count), .range_err(range_err), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [11:0] exp_mem [N];
  int          exp_count;
  int          exp_st;      // 0 idle, 1 collect, 2 done
  logic        exp_rerr;
  logic [11:0] rd_q [$];
  logic [11:0] exp_rd;

  function automatic logic [47:0] pack4(input int a, input int b, input int c, input int d);
    return {12'(d), 12'(c), 12'(b), 12'(a)};
  endfunction

  function automatic logic [11:0] exp_status();
    return {exp_st == 1, exp_st == 2, exp_rerr, 9'(exp_count)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_st = 0; exp_count = 0; exp_rerr = 1'b0;
  endtask

  // Drive one cycle of stimulus and advance the reference model.
  task automatic beat(input logic st, input logic v, input logic [3:0] acc, input logic [47:0] data);
    logic [11:0] val;
    start = st; sample_tvalid = v; acc_bus = acc; sample_tdata = data;
    tick();
    start = 1'b0; sample_tvalid = 1'b0; acc_bus = 4'h0;
    if (st) begin
      exp_st = 1; exp_count = 0; exp_rerr = 1'b0;
    end else if (exp_st == 1 && v) begin
      for (int i = 0; i < 4; i++) begin
        if (acc[i] && exp_count < N) begin
          val = data[i*12 +: 12];
          exp_mem[exp_count] = val;
          if (int'(val) >= Q) exp_rerr = 1'b1;
          exp_count++;
          if (exp_count == N) exp_st = 2;
        end
      end
    end
  endtask

  // Issue a read; the following address is applied before sampling so a
  // combinational read path would show the wrong word.
  task automatic rd_step(input logic [7:0] a);
    rd_addr = a;
    rd_q.push_back(exp_mem[a]);
    tick();
    rd_addr = a + 8'd1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sample_tvalid = 1'b0; acc_bus = 4'h0;
    sample_tdata = '0; rd_addr = 8'h0;
    tick(); tick();
    model_reset();
    n_checks++;
    if ({busy, done, range_err, count} !== exp_status()) begin
      n_errors++;
      $display("FAIL reset_status: got %h expected %h", {busy, done, range_err, count}, exp_status());
    end
    n_checks++;
    if (rd_data !== 12'h000) begin
      n_errors++;
      $display("FAIL reset_rd_data: got %h expected 000", rd_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_fill();
    beat(1'b1, 1'b0, 4'h0, '0);
    for (int b = 0; b < 64; b++) begin
      beat(1'b0, 1'b1, 4'hF, pack4(4*b, 4*b+1, 4*b+2, 4*b+3));
      n_checks++;
      if ({busy, done, range_err, count} !== exp_status()) begin
        n_errors++;
        $display("FAIL fill_status beat %0d: got %h expected %h", b, {busy, done, range_err, count}, exp_status());
      end
    end
    for (int j = 0; j < N; j++) begin
      rd_step(8'(j));
      exp_rd = rd_q.pop_front();
      n_checks++;
      if (rd_data !== exp_rd) begin
        n_errors++;
        $display("FAIL fill_read[%0d]: got %h expected %h", j, rd_data, exp_rd);
      end
    end
  endtask

  task automatic test_compaction();
    beat(1'b1, 1'b0, 4'h0, '0);
    rd_addr = 8'h0;
    rd_q.push_back(exp_mem[0]);
    beat(1'b0, 1'b1, 4'b1010, pack4('h111, 'h222, 'h333, 'h444));
    exp_rd = rd_q.pop_front();
    n_checks++;
    if (rd_data !== exp_rd) begin
      n_errors++;
      $display("FAIL same_addr_old_data: got %h expected %h", rd_data, exp_rd);
    end
    n_checks++;
    if ({busy, done, range_err, count} !== exp_status()) begin
      n_errors++;
      $display("FAIL compact_status1: got %h expected %h", {busy, done, range_err, count}, exp_status());
    end
    beat(1'b0, 1'b1, 4'b0001, pack4('h555, 'h666, 'h777, 'h888));
    beat(1'b0, 1'b1, 4'b0000, pack4('h999, 'h999, 'h999, 'h999));
    n_checks++;
    if ({busy, done, range_err, count} !== exp_status()) begin
      n_errors++;
      $display("FAIL compact_status2: got %h expected %h", {busy, done, range_err, count}, exp_status());
    end
    for (int j = 0; j < 4; j++) begin
      rd_step(8'(j));
      exp_rd = rd_q.pop_front();
      n_checks++;
      if (rd_data !== exp_rd) begin
        n_errors++;
        $display("FAIL compact_read[%0d]: got %h expected %h", j, rd_data, exp_rd);
      end
    end
  endtask

  task automatic test_overflow();
    beat(1'b1, 1'b0, 4'h0, '0);
    for (int b = 0; b < 63; b++) beat(1'b0, 1'b1, 4'hF, pack4(4*b, 4*b+1, 4*b+2, 4*b+3));
    beat(1'b0, 1'b1, 4'b0011, pack4('h100, 'h101, 'h102, 'h103));
    n_checks++;
    if ({busy, done, range_err, count} !== exp_status()) begin
      n_errors++;
      $display("FAIL ovf_at_254: got %h expected %h", {busy, done, range_err, count}, exp_status());
    end
    beat(1'b0, 1'b1, 4'hF, pack4('hA, 'hB, 'hC, 'hD));
    n_checks++;
    if ({busy, done, range_err, count} !== exp_status()) begin
      n_errors++;
      $display("FAIL ovf_full: got %h expected %h", {busy, done, range_err, count}, exp_status());
    end
    beat(1'b0, 1'b1, 4'hF, pack4('hE, 'hE, 'hE, 'hE));
    n_checks++;
    if ({busy, done, range_err, count} !== exp_status()) begin
      n_errors++;
      $display("FAIL ovf_after_full: got %h expected %h", {busy, done, range_err, count}, exp_status());
    end
    for (int j = 253; j < 256; j++) begin
      rd_step(8'(j));
      exp_rd = rd_q.pop_front();
      n_checks++;
      if (rd_data !== exp_rd) begin
        n_errors++;
        $display("FAIL ovf_read[%0d]: got %h expected %h", j, rd_data, exp_rd);
      end
    end
  endtask

  task automatic test_ignore_restart();
    rst = 1'b1; tick(); rst = 1'b0;
    model_reset();
    for (int b = 0; b < 3; b++) beat(1'b0, 1'b1, 4'hF, pack4('hF00, 'hF01, 'hF02, 'hF03));
    n_checks++;
    if ({busy, done, range_err, count} !== exp_status()) begin
      n_errors++;
      $display("FAIL idle_ignore: got %h expected %h", {busy, done, range_err, count}, exp_status());
    end
    beat(1'b1, 1'b0, 4'h0, '0);
    for (int b = 0; b < 10; b++) beat(1'b0, 1'b1, 4'hF, pack4('h300+4*b, 'h301+4*b, 'h302+4*b, 'h303+4*b));
    beat(1'b1, 1'b1, 4'hF, pack4('hEEE, 'hEEE, 'hEEE, 'hEEE));
    n_checks++;
    if ({busy, done, range_err, count} !== exp_status()) begin
      n_errors++;
      $display("FAIL restart_status: got %h expected %h", {busy, done, range_err, count}, exp_status());
    end
    for (int j = 0; j < 2; j++) begin
      rd_step(8'(j * 40));
      exp_rd = rd_q.pop_front();
      n_checks++;
      if (rd_data !== exp_rd) begin
        n_errors++;
        $display("FAIL restart_read[%0d]: got %h expected %h", j * 40, rd_data, exp_rd);
      end
    end
    for (int b = 0; b < 64; b++) beat(1'b0, 1'b1, 4'hF, pack4('h400+b, 'h500+b, 'h600+b, 'h700+b));
    beat(1'b0, 1'b1, 4'hF, pack4('hFFF, 'hFFF, 'hFFF, 'hFFF));
    n_checks++;
    if ({busy, done, range_err, count} !== exp_status()) begin
      n_errors++;
      $display("FAIL done_ignore: got %h expected %h", {busy, done, range_err, count}, exp_status());
    end
    rd_step(8'd0);
    exp_rd = rd_q.pop_front();
    n_checks++;
    if (rd_data !== exp_rd) begin
      n_errors++;
      $display("FAIL done_read0: got %h expected %h", rd_data, exp_rd);
    end
  endtask

  task automatic test_range();
    beat(1'b1, 1'b0, 4'h0, '0);
    beat(1'b0, 1'b1, 4'b0001, pack4(3328, 4095, 0, 0));
    n_checks++;
    if ({busy, done, range_err, count} !== exp_status()) begin
      n_errors++;
      $display("FAIL range_3328: got %h expected %h", {busy, done, range_err, count}, exp_status());
    end
    beat(1'b0, 1'b1, 4'b0001, pack4(3329, 1, 2, 3));
    n_checks++;
    if ({busy, done, range_err, count} !== exp_status()) begin
      n_errors++;
      $display("FAIL range_3329: got %h expected %h", {busy, done, range_err, count}, exp_status());
    end
    beat(1'b0, 1'b1, 4'hF, pack4(5, 6, 7, 8));
    n_checks++;
    if ({busy, done, range_err, count} !== exp_status()) begin
      n_errors++;
      $display("FAIL range_sticky: got %h expected %h", {busy, done, range_err, count}, exp_status());
    end
    rd_step(8'd1);
    exp_rd = rd_q.pop_front();
    n_checks++;
    if (rd_data !== exp_rd) begin
      n_errors++;
      $display("FAIL range_stored: got %h expected %h", rd_data, exp_rd);
    end
    beat(1'b1, 1'b0, 4'h0, '0);
    n_checks++;
    if ({busy, done, range_err, count} !== exp_status()) begin
      n_errors++;
      $display("FAIL range_cleared: got %h expected %h", {busy, done, range_err, count}, exp_status());
    end
  endtask

  task automatic test_reset_mid();
    beat(1'b1, 1'b0, 4'h0, '0);
    for (int b = 0; b < 25; b++) beat(1'b0, 1'b1, 4'hF, pack4(3400, 4*b+1, 4*b+2, 4*b+3));
    n_checks++;
    if ({busy, done, range_err, count} !== exp_status()) begin
      n_errors++;
      $display("FAIL pre_reset_100: got %h expected %h", {busy, done, range_err, count}, exp_status());
    end
    rst = 1'b1; start = 1'b1; sample_tvalid = 1'b1; acc_bus = 4'hF;
    tick();
    rst = 1'b0; start = 1'b0; sample_tvalid = 1'b0; acc_bus = 4'h0;
    model_reset();
    n_checks++;
    if ({busy, done, range_err, count} !== exp_status()) begin
      n_errors++;
      $display("FAIL mid_reset: got %h expected %h", {busy, done, range_err, count}, exp_status());
    end
    beat(1'b0, 1'b1, 4'hF, pack4(1, 2, 3, 4));
    n_checks++;
    if ({busy, done, range_err, count} !== exp_status()) begin
      n_errors++;
      $display("FAIL post_reset_idle: got %h expected %h", {busy, done, range_err, count}, exp_status());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_fill();
    test_compaction();
    test_overflow();
    test_ignore_restart();
    test_range();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
